// File: rtl/atm_pkg.sv
// Shared keypad/ATM definitions: key codes, keypad FSM states and the ATM data width.
package atm_pkg;

  localparam int ATM_DATA_W = 14;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_BKSP  = 4'hB;
  localparam logic [3:0] KEY_ENTER = 4'hC;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ENTRY   = 2'd1,
    CONVERT = 2'd2,
    HOLD    = 2'd3
  } keypad_state_t;

  function automatic logic is_digit(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

endpackage

// File: rtl/keypad_bcd_to_bin.sv
// Serial BCD->binary converter: Horner accumulation, most significant digit first, one digit per cycle.
module keypad_bcd_to_bin
  import atm_pkg::*;
#(
  parameter int MAX_DIGITS = 4,
  parameter int DATA_W     = ATM_DATA_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [4*MAX_DIGITS-1:0] digits,
  output logic [DATA_W-1:0]       acc,
  output logic                    done
);

  localparam int BUF_W  = 4 * MAX_DIGITS;
  localparam int STEP_W = $clog2(MAX_DIGITS + 1);

  logic [BUF_W-1:0]  sreg_q, sreg_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              active_q, active_d;
  logic              done_q, done_d;

  // Next-state for the shift register and accumulator; start consumes the first digit immediately.
  always_comb begin
    sreg_d   = sreg_q;
    step_d   = step_q;
    acc_d    = acc_q;
    active_d = active_q;
    done_d   = 1'b0;
    if (start) begin
      acc_d    = DATA_W'(digits[BUF_W-1 -: 4]);
      sreg_d   = {digits[BUF_W-5:0], 4'h0};
      step_d   = STEP_W'(1);
      active_d = (MAX_DIGITS > 1);
      done_d   = (MAX_DIGITS == 1);
    end else if (active_q) begin
      acc_d  = acc_q * DATA_W'(10) + DATA_W'(sreg_q[BUF_W-1 -: 4]);
      sreg_d = {sreg_q[BUF_W-5:0], 4'h0};
      step_d = step_q + STEP_W'(1);
      if (step_q == STEP_W'(MAX_DIGITS - 1)) begin
        active_d = 1'b0;
        done_d   = 1'b1;
      end else begin
        active_d = 1'b1;
      end
    end else begin
      active_d = 1'b0;
    end
  end

  // Converter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q   <= '0;
      step_q   <= '0;
      acc_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      sreg_q   <= sreg_d;
      step_q   <= step_d;
      acc_q    <= acc_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  assign acc  = acc_q;
  assign done = done_q;

endmodule

// File: rtl/atm_keypad_entry.sv
// Keypad entry stage: digit buffer, edit keys, serial conversion and valid/ack hold of the committed word.
// Optional idle timeout enabled by defining KEYPAD_TIMEOUT_EN.
module atm_keypad_entry
  import atm_pkg::*;
#(
  parameter int MAX_DIGITS     = 4,
  parameter int DATA_W         = ATM_DATA_W,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_valid,
  input  logic [3:0]        key_code,
  input  logic              field_sel,
  input  logic              entry_ack,
  output logic [DATA_W-1:0] pin,
  output logic [DATA_W-1:0] amount,
  output logic              entry_valid,
  output logic              entry_field,
  output logic [2:0]        digit_count,
  output logic              busy,
  output logic              key_error
);

  localparam int BUF_W = 4 * MAX_DIGITS;

  keypad_state_t     state_q, state_d;
  logic [BUF_W-1:0]  buf_q, buf_d;
  logic [2:0]        count_q, count_d;
  logic [DATA_W-1:0] pin_q, pin_d, amount_q, amount_d;
  logic              entry_valid_q, entry_valid_d;
  logic              entry_field_q, entry_field_d;
  logic              field_q, field_d;
  logic              busy_q, busy_d;
  logic              key_error_q, key_error_d;
  logic              start_s, conv_done_s, timeout_s, key_live_s;
  logic [DATA_W-1:0] conv_acc_s;

  // Codes 0xD-0xF never reach the FSM.
  assign key_live_s = key_valid && (key_code <= KEY_ENTER);

  keypad_bcd_to_bin #(.MAX_DIGITS(MAX_DIGITS), .DATA_W(DATA_W)) u_conv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start_s),
    .digits (buf_q),
    .acc    (conv_acc_s),
    .done   (conv_done_s)
  );

`ifdef KEYPAD_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] timer_q, timer_d;

  // Idle timer: runs only in ENTRY, reloads on every live key.
  always_comb begin
    timer_d   = '0;
    timeout_s = 1'b0;
    if (state_q == ENTRY) begin
      if (key_live_s) begin
        timer_d = '0;
      end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
        timeout_s = 1'b1;
      end else begin
        timer_d = timer_q + TMR_W'(1);
      end
    end else begin
      timer_d = '0;
    end
  end

  // Idle timer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  logic [31:0] unused_timeout_s;
  assign unused_timeout_s = 32'(TIMEOUT_CYCLES);
  assign timeout_s        = 1'b0;
`endif

  // FSM next-state, buffer editing, commit and handshake.
  always_comb begin
    state_d       = state_q;
    buf_d         = buf_q;
    count_d       = count_q;
    pin_d         = pin_q;
    amount_d      = amount_q;
    entry_valid_d = entry_valid_q;
    entry_field_d = entry_field_q;
    field_d       = field_q;
    key_error_d   = 1'b0;
    start_s       = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_live_s) begin
          if (is_digit(key_code)) begin
            buf_d   = {buf_q[BUF_W-5:0], key_code};
            count_d = 3'd1;
            field_d = field_sel;
            state_d = ENTRY;
          end else if (key_code == KEY_CLEAR) begin
            buf_d   = '0;
            count_d = 3'd0;
          end else begin
            key_error_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ENTRY: begin
        if (timeout_s) begin
          buf_d       = '0;
          count_d     = 3'd0;
          key_error_d = 1'b1;
          state_d     = IDLE;
        end else if (key_live_s) begin
          if (is_digit(key_code)) begin
            if (count_q == 3'(MAX_DIGITS)) begin
              key_error_d = 1'b1;
            end else begin
              buf_d   = {buf_q[BUF_W-5:0], key_code};
              count_d = count_q + 3'd1;
            end
          end else if (key_code == KEY_CLEAR) begin
            buf_d   = '0;
            count_d = 3'd0;
            state_d = IDLE;
          end else if (key_code == KEY_BKSP) begin
            buf_d   = {4'h0, buf_q[BUF_W-1:4]};
            count_d = count_q - 3'd1;
            state_d = (count_q == 3'd1) ? IDLE : ENTRY;
          end else begin
            start_s = 1'b1;
            state_d = CONVERT;
          end
        end else begin
          state_d = ENTRY;
        end
      end
      CONVERT: begin
        key_error_d = key_live_s;
        if (conv_done_s) begin
          if (field_q) begin
            amount_d = conv_acc_s;
          end else begin
            pin_d = conv_acc_s;
          end
          entry_valid_d = 1'b1;
          entry_field_d = field_q;
          state_d       = HOLD;
        end else begin
          state_d = CONVERT;
        end
      end
      HOLD: begin
        key_error_d = key_live_s;
        if (entry_ack) begin
          entry_valid_d = 1'b0;
          buf_d         = '0;
          count_d       = 3'd0;
          state_d       = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == CONVERT) || (state_d == HOLD);
  end

  // FSM and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      buf_q         <= '0;
      count_q       <= 3'd0;
      pin_q         <= '0;
      amount_q      <= '0;
      entry_valid_q <= 1'b0;
      entry_field_q <= 1'b0;
      field_q       <= 1'b0;
      busy_q        <= 1'b0;
      key_error_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      buf_q         <= buf_d;
      count_q       <= count_d;
      pin_q         <= pin_d;
      amount_q      <= amount_d;
      entry_valid_q <= entry_valid_d;
      entry_field_q <= entry_field_d;
      field_q       <= field_d;
      busy_q        <= busy_d;
      key_error_q   <= key_error_d;
    end
  end

  assign pin         = pin_q;
  assign amount      = amount_q;
  assign entry_valid = entry_valid_q;
  assign entry_field = entry_field_q;
  assign digit_count = count_q;
  assign busy        = busy_q;
  assign key_error   = key_error_q;

endmodule

// File: tb/tb_atm_keypad_entry.sv
// Self-checking bench for atm_keypad_entry: directed scenarios plus random keys against a digit-list model.
module tb_atm_keypad_entry;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic        field_sel = 1'b0;
  logic        entry_ack = 1'b0;
  logic [13:0] pin, amount;
  logic        entry_valid, entry_field, busy, key_error;
  logic [2:0]  digit_count;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_pin  = 0;
  int exp_amt  = 0;

  atm_keypad_entry #(.MAX_DIGITS(4), .DATA_W(14), .TIMEOUT_CYCLES(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .field_sel   (field_sel),
    .entry_ack   (entry_ack),
    .pin         (pin),
    .amount      (amount),
    .entry_valid (entry_valid),
    .entry_field (entry_field),
    .digit_count (digit_count),
    .busy        (busy),
    .key_error   (key_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] c);
    key_valid = 1'b1;
    key_code  = c;
    @(posedge clk); #1;
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Called just after the ENTER edge (plus any extra cycles already spent); n = remaining cycles before commit.
  task automatic commit_check(input int n, input logic fld);
    repeat (n) begin
      @(posedge clk); #1;
      chk("conv_valid_low", entry_valid, 0);
      chk("conv_busy", busy, 1);
    end
    @(posedge clk); #1;
    chk("commit_valid", entry_valid, 1);
    chk("commit_pin", pin, exp_pin);
    chk("commit_amount", amount, exp_amt);
    chk("commit_field", entry_field, fld);
  endtask

  task automatic ack();
    entry_ack = 1'b1;
    @(posedge clk); #1;
    entry_ack = 1'b0;
    chk("ack_valid", entry_valid, 0);
    chk("ack_busy", busy, 0);
    chk("ack_count", digit_count, 0);
  endtask

  initial begin : main
    int digs[$];
    int val;
    int r;
    logic [3:0] code;
    logic fs, fld_m, exp_err, do_commit;

    // Reset state
    idle(3);
    chk("rst_pin", pin, 0);
    chk("rst_amount", amount, 0);
    chk("rst_valid", entry_valid, 0);
    chk("rst_field", entry_field, 0);
    chk("rst_count", digit_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", key_error, 0);
    rst_n = 1'b1;
    idle(1);

    // Reset in the middle of a conversion
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    chk("pre_cnt4", digit_count, 4);
    press(4'hC);
    idle(1);
    rst_n = 1'b0;
    #2;
    chk("midrst_valid", entry_valid, 0);
    chk("midrst_busy", busy, 0);
    @(posedge clk); #1;
    chk("midrst_valid2", entry_valid, 0);
    chk("midrst_pin", pin, 0);
    chk("midrst_count", digit_count, 0);
    rst_n = 1'b1;
    idle(6);
    chk("midrst_no_commit", entry_valid, 0);

    // PIN 1234
    field_sel = 1'b0;
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    press(4'hC);
    exp_pin = 1234;
    commit_check(3, 1'b0);
    idle(3);
    chk("hold_valid", entry_valid, 1);
    chk("hold_busy", busy, 1);
    ack();

    // Amount 57 with a backspace and a key dropped mid-conversion
    field_sel = 1'b1;
    press(4'd5); press(4'd0);
    chk("cnt2", digit_count, 2);
    press(4'hB);
    chk("bksp_cnt", digit_count, 1);
    chk("bksp_err", key_error, 0);
    press(4'd7);
    press(4'hC);
    press(4'd8);
    chk("conv_key_err", key_error, 1);
    exp_amt = 57;
    commit_check(2, 1'b1);
    chk("pin_kept", pin, 1234);
    ack();

    // Overfill then 9999, digit in HOLD, ack+key same cycle
    field_sel = 1'b0;
    press(4'd9); press(4'd9); press(4'd9); press(4'd9);
    chk("full_err0", key_error, 0);
    press(4'd9);
    chk("overfill_err", key_error, 1);
    chk("overfill_cnt", digit_count, 4);
    press(4'hC);
    chk("enter_err0", key_error, 0);
    exp_pin = 9999;
    commit_check(3, 1'b0);
    chk("max_amount_kept", amount, 57);
    press(4'd3);
    chk("hold_key_err", key_error, 1);
    chk("hold_key_valid", entry_valid, 1);
    chk("hold_key_cnt", digit_count, 4);
    entry_ack = 1'b1; key_valid = 1'b1; key_code = 4'd6;
    @(posedge clk); #1;
    entry_ack = 1'b0; key_valid = 1'b0;
    chk("ackkey_err", key_error, 1);
    chk("ackkey_valid", entry_valid, 0);
    chk("ackkey_cnt", digit_count, 0);
    chk("ackkey_pin", pin, 9999);

    // Errors at count zero, clear and ignored codes silent, stray ack ignored
    press(4'hC);
    chk("enter0_err", key_error, 1);
    chk("enter0_busy", busy, 0);
    press(4'hB);
    chk("bksp0_err", key_error, 1);
    chk("bksp0_cnt", digit_count, 0);
    press(4'hA);
    chk("clear0_err", key_error, 0);
    press(4'hE);
    chk("ignored_err", key_error, 0);
    entry_ack = 1'b1;
    idle(1);
    entry_ack = 1'b0;
    chk("stray_ack_valid", entry_valid, 0);

    // Idle timeout behaviour
    press(4'd3);
    chk("to_cnt1", digit_count, 1);
    idle(7);
    chk("to_pre_cnt", digit_count, 1);
    idle(1);
`ifdef KEYPAD_TIMEOUT_EN
    chk("to_cnt", digit_count, 0);
    chk("to_err", key_error, 1);
`else
    chk("to_cnt", digit_count, 1);
    chk("to_err", key_error, 0);
`endif
    press(4'hA);
    chk("to_clear_cnt", digit_count, 0);

    // Random keys against a digit-list model
    fld_m = 1'b0;
    for (int i = 0; i < 300; i++) begin
      fs = 1'($urandom_range(0, 1));
      field_sel = fs;
      r = $urandom_range(0, 19);
      if (r <= 12)      code = 4'(r);
      else if (r <= 15) code = 4'hC;
      else if (r == 16) code = 4'hD;
      else if (r == 17) code = 4'hE;
      else              code = 4'hF;
      if (r == 11 || r == 12) code = 4'hB;
      exp_err = 1'b0;
      do_commit = 1'b0;
      if (code <= 4'd9) begin
        if (digs.size() == 4) exp_err = 1'b1;
        else begin
          if (digs.size() == 0) fld_m = fs;
          digs.push_back(int'(code));
        end
      end else if (code == 4'hA) begin
        digs.delete();
      end else if (code == 4'hB) begin
        if (digs.size() == 0) exp_err = 1'b1;
        else void'(digs.pop_back());
      end else if (code == 4'hC) begin
        if (digs.size() == 0) exp_err = 1'b1;
        else do_commit = 1'b1;
      end
      press(code);
      chk("rnd_err", key_error, exp_err);
      chk("rnd_cnt", digit_count, digs.size());
      if (do_commit) begin
        val = 0;
        foreach (digs[j]) val = val * 10 + digs[j];
        if (fld_m) exp_amt = val;
        else       exp_pin = val;
        commit_check(3, fld_m);
        idle($urandom_range(0, 2));
        ack();
        digs.delete();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
